// File: rtl/psum_accum_requant_pkg.sv
// Shared types and constants for the partial-sum accumulator and requantizer.
// The MAC mode encoding must stay in step with the MAC datapath.
package psum_accum_requant_pkg;

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_REQ   = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int VSQ_SHIFT = 8;
  localparam int OUT_MAX   = 127;
  localparam int OUT_MIN   = -128;

endpackage

// File: rtl/psum_accum_requant_requant_sat.sv
// Combinational requantizer: deferred VSQ rescale, round-half-up arithmetic
// right shift, then clamp to the signed output range.
module psum_accum_requant_requant_sat
  import psum_accum_requant_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  mode_e                   mode_i,
  input  logic        [4:0]       shift_i,
  output logic signed [OUT_W-1:0] data_o
);

  // One guard bit above the rescaled range keeps the rounding add from overflowing.
  localparam int X_W = ACC_W + VSQ_SHIFT + 1;

  localparam logic signed [X_W-1:0]   SAT_MAX = X_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [X_W-1:0]   SAT_MIN = ~SAT_MAX;
  localparam logic signed [OUT_W-1:0] MAX_O   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O   = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [X_W-1:0] round_shift(
    input logic signed [X_W-1:0] x,
    input logic        [4:0]     sh
  );
    logic signed [X_W-1:0] bias;
    bias = (sh == 5'd0) ? '0 : (X_W'(1) << (sh - 5'd1));
    return (x + bias) >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [X_W-1:0] y
  );
    if (y > SAT_MAX)      return MAX_O;
    else if (y < SAT_MIN) return MIN_O;
    else                  return y[OUT_W-1:0];
  endfunction

  logic signed [X_W-1:0] x;

  always_comb begin
    x = {{(X_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    if (mode_i == MODE_INT4_VSQ) x = x <<< VSQ_SHIFT;
    data_o = saturate(round_shift(x, shift_i));
  end

endmodule

// File: rtl/psum_accum_requant.sv
// Partial-sum accumulator behind the combinational MAC: feeds psum back,
// counts K tiles, then requantizes once and offers the result on valid/ready.
module psum_accum_requant
  import psum_accum_requant_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8,
  parameter int OUT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic        [1:0]       i_mode,
  input  logic        [CNT_W-1:0] i_num_tiles,
  input  logic        [4:0]       i_shift,
  input  logic                    i_mac_valid,
  output logic                    o_mac_ready,
  input  logic signed [ACC_W-1:0] i_mac_result,
  output logic signed [ACC_W-1:0] o_psum,
  output logic        [1:0]       o_mode,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic signed [OUT_W-1:0] o_out_data,
  output logic                    o_busy
);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;
  logic        [CNT_W-1:0] tiles_q;
  mode_e                   mode_q;
  logic        [4:0]       shift_q;
  logic signed [OUT_W-1:0] out_q;
  logic signed [OUT_W-1:0] req_d;

  psum_accum_requant_requant_sat #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_requant_sat (
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .shift_i(shift_q),
    .data_o (req_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tiles_q <= '0;
      mode_q  <= MODE_INT8;
      shift_q <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && (i_num_tiles != '0)) begin
            mode_q  <= mode_e'(i_mode);
            tiles_q <= i_num_tiles;
            shift_q <= i_shift;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (i_mac_valid) begin
            acc_q <= i_mac_result;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == tiles_q - CNT_W'(1)) state_q <= S_REQ;
          end
        end
        S_REQ: begin
          out_q   <= req_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (i_out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mac_ready = (state_q == S_ACCUM);
  assign o_out_valid = (state_q == S_OUT);
  assign o_busy      = (state_q != S_IDLE);
  assign o_psum      = acc_q;
  assign o_mode      = mode_q;
  assign o_out_data  = out_q;

endmodule

// File: doc/psum_accum_requant.md
Name: psum_accum_requant

Overview:
- Sequential accumulation and output stage placed directly downstream of the combinational MAC.
- Holds the running partial sum, drives it back into the MAC psum input, and counts K-dimension tiles.
- After the last tile it applies the deferred VSQ <<8 rescale, round-shifts, saturates to INT8, and hands the result downstream on a valid/ready handshake.

Parameters:
- ACC_W, 24, width of the MAC result and the partial sum.
- CNT_W, 8, width of the tile counter and of i_num_tiles.
- OUT_W, 8, width of the requantized output.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin a new dot-product job; sampled only in IDLE.
- i_mode  in  2  INT8 / INT4 / INT4_VSQ, same encoding as define.vh; latched on start.
- i_num_tiles  in  CNT_W  number of MAC tiles to accumulate; latched on start.
- i_shift  in  5  requant right-shift amount; latched on start.
- i_mac_valid  in  1  i_mac_result is valid this cycle.
- o_mac_ready  out  1  block accepts a MAC result this cycle.
- i_mac_result  in  ACC_W  MAC output, i.e. psum + dot product.
- o_psum  out  ACC_W  accumulator register, wired to the MAC psum input.
- o_mode  out  2  latched mode, wired to the MAC mode input.
- o_out_valid  out  1  requantized result available.
- i_out_ready  in  1  downstream accepts the result.
- o_out_data  out  OUT_W  signed saturated result.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; acc, cnt, mode, shift, o_out_data all 0.
  - o_mac_ready=0, o_out_valid=0, o_busy=0.
- The block is reset-safe mid-job: the job is discarded, no output is produced, and the next start works normally.
- States: IDLE, ACCUM, REQ, OUT.
- IDLE:
  - Condition to leave: i_start=1 and i_num_tiles!=0.
  - On that cycle: latch mode, num_tiles, shift; clear acc to 0 and cnt to 0; go to ACCUM.
  - i_start with i_num_tiles=0 is ignored and the block stays in IDLE.
- i_start outside IDLE is ignored.
- ACCUM:
  - o_mac_ready=1.
  - On i_mac_valid & o_mac_ready: acc <= i_mac_result and cnt <= cnt+1.
  - If cnt == num_tiles-1 at acceptance, go to REQ on the next edge.
  - i_mac_valid=0 stalls with no state change.
- o_psum=acc at all times. The first tile therefore sees psum=0; each later tile sees the previous result.
- No saturation is applied in acc. In VSQ mode, saturation is already done inside the MAC.
- REQ (1 cycle, o_mac_ready=0):
  - x = sign-extend(acc) to 33 bits.
  - If mode==INT4_VSQ: x = x <<< 8.
  - If shift>0: y = (x + 2^(shift-1)) >>> shift (round half up, arithmetic). If shift=0: y = x.
  - o_out_data = clamp(y, -128, 127).
  - Register the result and go to OUT.
- OUT:
  - o_out_valid=1; o_out_data is held stable until the handshake.
  - On i_out_ready=1: o_out_valid drops next cycle and state goes to IDLE.
  - i_start on that same cycle is ignored, because start is only sampled in IDLE.
- Latency:
  - Last tile accepted at cycle t → o_out_valid=1 at cycle t+2.
  - Minimum job (1 tile): start at t0, tile at t0+1, valid at t0+3.
- Counter: cnt never wraps. i_num_tiles=255 gives 255 accepts.
- o_busy = (state != IDLE).

Decomposition:
- define.vh (shared):
  - Existing INT8/INT4/INT4_VSQ macros.
  - New state encodings S_IDLE=0, S_ACCUM=1, S_REQ=2, S_OUT=3.
  - New macros ACC_W=24, VSQ_SHIFT=8, OUT_MAX=127, OUT_MIN=-128.
- Sub-module requant_sat:
  - Combinational; inputs acc, mode, shift; output int8.
  - Implements the <<8, rounding shift and clamp.
  - Unit-testable standalone.
- FSM, counter and registers stay in the top module.

Test Plan:
- INT8, num_tiles=3, shift=0, MAC results 10, 25, 40 (bench models psum+dp) → o_psum sequence 0, 10, 25; o_out_data=40; valid 2 cycles after the 3rd accept.
- INT4_VSQ, num_tiles=1, result 3, shift=4 → x=768, y=(768+8)>>4=48, out=48.
- Saturation in INT8 mode, shift=0:
  - acc=1000 → out=127.
  - acc=-1000 → out=-128.
  - acc=-129 with shift=0 → -128.
- Rounding, INT4, shift=2:
  - acc=6 → (6+2)>>2=2.
  - acc=-6 → (-4)>>>2=-1.
  - acc=5 → 1.
- Handshake and stall:
  - i_mac_valid gaps between tiles → cnt does not advance.
  - i_out_ready held 0 for 5 cycles → o_out_data stable, o_out_valid=1 throughout.
  - i_start during ACCUM is ignored.
- Reset mid-ACCUM after 2 of 4 tiles → all outputs 0 and state IDLE; a new job with num_tiles=1 then completes correctly.
- i_start with num_tiles=0 → o_busy stays 0.
